// File: rtl/pll_reset_sequencer_if.sv
// rtl/pll_reset_sequencer_if.sv - PLL lock input and staged reset outputs of the sequencer
interface pll_reset_sequencer_if;
   logic       pll_locked;
   logic       mem_rst_n;
   logic       cpu_rst_n;
   logic       vid_rst_n;
   logic       ready;
   logic [7:0] relock_count;

   modport master (
      input  pll_locked,
      output mem_rst_n,
      output cpu_rst_n,
      output vid_rst_n,
      output ready,
      output relock_count
   );

   modport slave (
      output pll_locked,
      input  mem_rst_n,
      input  cpu_rst_n,
      input  vid_rst_n,
      input  ready,
      input  relock_count
   );
endinterface

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - synchronises PLL lock, filters it, releases mem/cpu/vid resets in order
module pll_reset_sequencer #(
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int STAGE_GAP          = 16,
   parameter int CNT_W              = 16
) (
   input  logic                  clock,
   input  logic                  reset_n,
   pll_reset_sequencer_if.master seq_if
);

   typedef enum logic [2:0] {
      S_WAIT_LOCK,
      S_STABLE,
      S_REL_MEM,
      S_REL_CPU,
      S_RUN
   } state_t;

   localparam logic [CNT_W-1:0] C_STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_GAP_LAST    = CNT_W'(STAGE_GAP - 1);

   logic             r_sync1;
   logic             r_locked_s;
   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_mem;
   logic             r_cpu;
   logic             r_vid;
   logic             r_ready;
   logic [7:0]       r_relock;

   state_t           w_state_nx;
   logic [CNT_W-1:0] w_cnt_nx;
   logic             w_mem_nx;
   logic             w_cpu_nx;
   logic             w_vid_nx;
   logic             w_ready_nx;
   logic [7:0]       w_relock_nx;

   // Two-flop synchroniser: the only place the raw lock signal is sampled.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1    <= 1'b0;
         r_locked_s <= 1'b0;
      end else begin
         r_sync1    <= seq_if.pll_locked;
         r_locked_s <= r_sync1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= S_WAIT_LOCK;
         r_cnt    <= '0;
         r_mem    <= 1'b0;
         r_cpu    <= 1'b0;
         r_vid    <= 1'b0;
         r_ready  <= 1'b0;
         r_relock <= 8'd0;
      end else begin
         r_state  <= w_state_nx;
         r_cnt    <= w_cnt_nx;
         r_mem    <= w_mem_nx;
         r_cpu    <= w_cpu_nx;
         r_vid    <= w_vid_nx;
         r_ready  <= w_ready_nx;
         r_relock <= w_relock_nx;
      end
   end

   always_comb begin
      w_state_nx  = r_state;
      w_cnt_nx    = r_cnt;
      w_mem_nx    = r_mem;
      w_cpu_nx    = r_cpu;
      w_vid_nx    = r_vid;
      w_ready_nx  = r_ready;
      w_relock_nx = r_relock;

      unique case (r_state)
         S_WAIT_LOCK: begin
            w_cnt_nx   = '0;
            w_mem_nx   = 1'b0;
            w_cpu_nx   = 1'b0;
            w_vid_nx   = 1'b0;
            w_ready_nx = 1'b0;
            if (r_locked_s) begin
               w_state_nx = S_STABLE;
               w_cnt_nx   = CNT_W'(1);
            end
         end
         S_STABLE: begin
            if (r_cnt == C_STABLE_LAST) begin
               w_state_nx = S_REL_MEM;
               w_cnt_nx   = '0;
               w_mem_nx   = 1'b1;
            end else begin
               w_cnt_nx = r_cnt + 1'b1;
            end
         end
         S_REL_MEM: begin
            w_cnt_nx = r_cnt + 1'b1;
            if (r_cnt == C_GAP_LAST) begin
               w_state_nx = S_REL_CPU;
               w_cnt_nx   = '0;
               w_cpu_nx   = 1'b1;
            end
         end
         S_REL_CPU: begin
            w_cnt_nx = r_cnt + 1'b1;
            if (r_cnt == C_GAP_LAST) begin
               w_state_nx = S_RUN;
               w_cnt_nx   = '0;
               w_vid_nx   = 1'b1;
               w_ready_nx = 1'b1;
            end
         end
         S_RUN: begin
            w_cnt_nx = '0;
         end
         default: begin
            w_state_nx = S_WAIT_LOCK;
            w_cnt_nx   = '0;
         end
      endcase

      // Lock loss overrides every state transition and drops all resets together.
      if (r_state != S_WAIT_LOCK && !r_locked_s) begin
         w_state_nx = S_WAIT_LOCK;
         w_cnt_nx   = '0;
         w_mem_nx   = 1'b0;
         w_cpu_nx   = 1'b0;
         w_vid_nx   = 1'b0;
         w_ready_nx = 1'b0;
         if (r_state == S_RUN && r_relock != 8'hFF) begin
            w_relock_nx = r_relock + 8'd1;
         end
      end
   end

   assign seq_if.mem_rst_n    = r_mem;
   assign seq_if.cpu_rst_n    = r_cpu;
   assign seq_if.vid_rst_n    = r_vid;
   assign seq_if.ready        = r_ready;
   assign seq_if.relock_count = r_relock;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - scoreboard bench for the staged PLL reset sequencer
module tb_pll_reset_sequencer;

   localparam int L = 8;
   localparam int G = 4;

   typedef struct {
      int kind;
      int edge_n;
   } rel_t;

   logic clock;
   logic reset_n;
   int   edge_cnt;
   int   errors;
   int   checks;
   int   exp_relock;
   rel_t sb[$];
   logic [2:0] prev_rel;

   pll_reset_sequencer_if bus ();

   pll_reset_sequencer #(
      .LOCK_STABLE_CYCLES(L),
      .STAGE_GAP(G),
      .CNT_W(16)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .seq_if(bus.master)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial edge_cnt = 0;
   always @(posedge clock) edge_cnt++;

   // Scoreboard consumer: every rising reset output must match the next expected release.
   initial prev_rel = 3'b000;
   always @(negedge clock) begin
      logic [2:0] cur;
      rel_t it;
      cur = {bus.vid_rst_n, bus.cpu_rst_n, bus.mem_rst_n};
      for (int k = 0; k < 3; k++) begin
         if (cur[k] === 1'b1 && prev_rel[k] !== 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_release kind=%0d at edge %0d, required none", k, edge_cnt);
            end else begin
               it = sb.pop_front();
               if (it.kind !== k || it.edge_n !== edge_cnt) begin
                  errors++;
                  $display("FAIL release_timing got kind=%0d edge=%0d, required kind=%0d edge=%0d",
                           k, edge_cnt, it.kind, it.edge_n);
               end
            end
            if (k == 2) begin
               checks++;
               if (bus.ready !== 1'b1) begin
                  errors++;
                  $display("FAIL ready_with_vid got %b, required 1", bus.ready);
               end
            end
         end
      end
      prev_rel = cur;
   end

   task automatic push_release(input int e0, input int n);
      rel_t it;
      for (int k = 0; k < n; k++) begin
         it.kind   = k;
         it.edge_n = e0 + 1 + L + k * G;
         sb.push_back(it);
      end
   endtask

   task automatic drain(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clock);
         if (sb.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset_n        = 1'b0;
      bus.pll_locked = 1'b0;
      #1;
      checks += 5;
      if (bus.mem_rst_n !== 1'b0) begin errors++; $display("FAIL reset_mem got %b, required 0", bus.mem_rst_n); end
      if (bus.cpu_rst_n !== 1'b0) begin errors++; $display("FAIL reset_cpu got %b, required 0", bus.cpu_rst_n); end
      if (bus.vid_rst_n !== 1'b0) begin errors++; $display("FAIL reset_vid got %b, required 0", bus.vid_rst_n); end
      if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b, required 0", bus.ready); end
      if (bus.relock_count !== 8'd0) begin errors++; $display("FAIL reset_relock got %0d, required 0", bus.relock_count); end
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      repeat (3) @(negedge clock);
   endtask

   task automatic test_staged_release();
      bit ok;
      int e0;
      e0 = edge_cnt + 1;
      bus.pll_locked = 1'b1;
      push_release(e0, 3);
      drain(L + 2 * G + 10, ok);
      checks += 2;
      if (!ok) begin errors++; $display("FAIL staged_timeout pending=%0d, required 0", sb.size()); end
      if (bus.relock_count !== 8'd0) begin errors++; $display("FAIL staged_relock got %0d, required 0", bus.relock_count); end
   endtask

   task automatic test_lock_loss_run();
      bit ok;
      int e0;
      bus.pll_locked = 1'b0;
      @(negedge clock);
      @(negedge clock);
      checks++;
      if (bus.ready !== 1'b1) begin errors++; $display("FAIL loss_early_drop ready got %b, required 1", bus.ready); end
      @(negedge clock);
      exp_relock = 1;
      checks += 5;
      if (bus.mem_rst_n !== 1'b0) begin errors++; $display("FAIL loss_mem got %b, required 0", bus.mem_rst_n); end
      if (bus.cpu_rst_n !== 1'b0) begin errors++; $display("FAIL loss_cpu got %b, required 0", bus.cpu_rst_n); end
      if (bus.vid_rst_n !== 1'b0) begin errors++; $display("FAIL loss_vid got %b, required 0", bus.vid_rst_n); end
      if (bus.ready !== 1'b0) begin errors++; $display("FAIL loss_ready got %b, required 0", bus.ready); end
      if (bus.relock_count !== exp_relock[7:0]) begin errors++; $display("FAIL loss_relock got %0d, required %0d", bus.relock_count, exp_relock); end
      e0 = edge_cnt + 1;
      bus.pll_locked = 1'b1;
      push_release(e0, 3);
      drain(L + 2 * G + 10, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL relock_timeout pending=%0d, required 0", sb.size()); end
   endtask

   task automatic test_glitch_stable();
      bit ok;
      int e0;
      bus.pll_locked = 1'b0;
      repeat (3) @(negedge clock);
      exp_relock++;
      repeat (4) @(negedge clock);
      e0 = edge_cnt + 1;
      bus.pll_locked = 1'b1;
      while (edge_cnt < e0 + 4) @(negedge clock);
      bus.pll_locked = 1'b0;
      repeat (3) @(negedge clock);
      e0 = edge_cnt + 1;
      bus.pll_locked = 1'b1;
      push_release(e0, 3);
      drain(L + 2 * G + 10, ok);
      checks += 2;
      if (!ok) begin errors++; $display("FAIL glitch_timeout pending=%0d, required 0", sb.size()); end
      if (bus.relock_count !== exp_relock[7:0]) begin errors++; $display("FAIL glitch_relock got %0d, required %0d", bus.relock_count, exp_relock); end
   endtask

   task automatic test_saturation();
      bit ok;
      int e0;
      for (int i = 0; i < 260; i++) begin
         bus.pll_locked = 1'b0;
         repeat (3) @(negedge clock);
         if (exp_relock < 255) exp_relock++;
         checks++;
         if (bus.relock_count !== exp_relock[7:0]) begin
            errors++;
            $display("FAIL sat_relock iter=%0d got %0d, required %0d", i, bus.relock_count, exp_relock);
         end
         e0 = edge_cnt + 1;
         bus.pll_locked = 1'b1;
         push_release(e0, 3);
         drain(L + 2 * G + 10, ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL sat_timeout iter=%0d pending=%0d, required 0", i, sb.size()); end
      end
      checks++;
      if (bus.relock_count !== 8'd255) begin errors++; $display("FAIL sat_final got %0d, required 255", bus.relock_count); end
   endtask

   task automatic test_async_reset_mid();
      bit ok;
      int e0;
      bus.pll_locked = 1'b0;
      repeat (3) @(negedge clock);
      e0 = edge_cnt + 1;
      bus.pll_locked = 1'b1;
      push_release(e0, 1);
      drain(L + 10, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL mid_mem_timeout pending=%0d, required 0", sb.size()); end
      @(negedge clock);
      #2 reset_n = 1'b0;
      #1;
      exp_relock = 0;
      checks += 4;
      if (bus.mem_rst_n !== 1'b0) begin errors++; $display("FAIL async_mem got %b, required 0", bus.mem_rst_n); end
      if (bus.cpu_rst_n !== 1'b0) begin errors++; $display("FAIL async_cpu got %b, required 0", bus.cpu_rst_n); end
      if (bus.ready !== 1'b0) begin errors++; $display("FAIL async_ready got %b, required 0", bus.ready); end
      if (bus.relock_count !== 8'd0) begin errors++; $display("FAIL async_relock got %0d, required 0", bus.relock_count); end
      @(negedge clock);
      reset_n = 1'b1;
      e0 = edge_cnt + 1;
      push_release(e0, 3);
      drain(L + 2 * G + 10, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL restart_timeout pending=%0d, required 0", sb.size()); end
   endtask

   task automatic test_no_lock();
      @(negedge clock);
      reset_n        = 1'b0;
      bus.pll_locked = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         repeat (20) @(negedge clock);
         checks++;
         if ({bus.mem_rst_n, bus.cpu_rst_n, bus.vid_rst_n, bus.ready} !== 4'b0000) begin
            errors++;
            $display("FAIL no_lock_outputs got %b, required 0000",
                     {bus.mem_rst_n, bus.cpu_rst_n, bus.vid_rst_n, bus.ready});
         end
      end
   endtask

   initial begin
      errors     = 0;
      checks     = 0;
      exp_relock = 0;
      test_reset();
      test_staged_release();
      test_lock_loss_run();
      test_glitch_stable();
      test_saturation();
      test_async_reset_mid();
      test_no_lock();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
